// File: rtl/video_timing_gen_if.sv
// ---------------------------------------------------------------------------
// video_timing_gen_if
//   Bundle carrying the raster timing between the timing generator and the
//   pixel datapath (pattern stage, DVI/VGA output).
//
//   Signals
//     en           pixel-clock enable into the generator
//     VX, VY       11-bit raster coordinates
//     VIDEN        active-video flag
//     HSYNC/VSYNC  sync pulses (polarity set by the generator parameters)
//     line_start   one-cycle pulse at VX==0
//     frame_start  one-cycle pulse at VX==0, VY==0
//
//   Modports
//     master  timing generator: drives timing, receives en
//     slave   datapath consumer: drives en, receives timing
// ---------------------------------------------------------------------------
interface video_timing_gen_if;
    logic        en;
    logic [10:0] VX;
    logic [10:0] VY;
    logic        VIDEN;
    logic        HSYNC;
    logic        VSYNC;
    logic        line_start;
    logic        frame_start;

    modport master (
        input  en,
        output VX, VY, VIDEN, HSYNC, VSYNC, line_start, frame_start
    );

    modport slave (
        output en,
        input  VX, VY, VIDEN, HSYNC, VSYNC, line_start, frame_start
    );
endinterface

// File: rtl/video_timing_gen.sv
// ---------------------------------------------------------------------------
// video_timing_gen
//   Free-running raster timing controller. H/V counters produce the pixel
//   coordinates, the active-video flag, sync pulses and line/frame strobes.
//   Default timing is 800x600@60 Hz at a 40 MHz pixel clock.
//
//   Ports
//     clk    pixel clock
//     rst_n  synchronous reset, active-low (dominates en)
//     vt     timing bundle (master side): en in; VX, VY, VIDEN, HSYNC,
//            VSYNC, line_start, frame_start out -- all registered
//
//   Every output flop is loaded from a decode of the *next* coordinates, so
//   the decoded flags always line up with the VX/VY registers they describe.
// ---------------------------------------------------------------------------
module video_timing_gen #(
    parameter int unsigned H_ACTIVE = 800,
    parameter int unsigned H_FP     = 40,
    parameter int unsigned H_SYNC   = 128,
    parameter int unsigned H_BP     = 88,
    parameter int unsigned V_ACTIVE = 600,
    parameter int unsigned V_FP     = 1,
    parameter int unsigned V_SYNC   = 4,
    parameter int unsigned V_BP     = 23,
    parameter bit          HS_POL   = 1'b1,
    parameter bit          VS_POL   = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    video_timing_gen_if.master vt
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Counters are 11 bits wide; larger rasters cannot be represented.
    if ((H_TOTAL > 2048) || (V_TOTAL > 2048)) begin : g_size_check
        $error("video_timing_gen: H_TOTAL and V_TOTAL must be <= 2048");
    end

    localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST     = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_ACTIVE_W = 11'(H_ACTIVE);
    localparam logic [10:0] V_ACTIVE_W = 11'(V_ACTIVE);
    localparam logic [10:0] HS_START   = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END     = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] VS_START   = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END     = 11'(V_ACTIVE + V_FP + V_SYNC);

    // ST_PRIME: just out of reset, outputs still show reset values. The first
    // enabled cycle loads (0,0) without counting, so frame_start and VIDEN
    // appear together with VX=0, VY=0.
    typedef enum logic {
        ST_PRIME,
        ST_RUN
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [10:0] vx_q;
    logic [10:0] vy_q;
    logic [10:0] vx_next;
    logic [10:0] vy_next;

    logic        viden_q;
    logic        hsync_q;
    logic        vsync_q;
    logic        line_start_q;
    logic        frame_start_q;

    logic        viden_next;
    logic        hsync_next;
    logic        vsync_next;
    logic        line_start_next;
    logic        frame_start_next;

    // Next-state coordinates and their decode.
    // NOTE: every variable gets a default before any branch, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_next = state;
        vx_next    = vx_q;
        vy_next    = vy_q;

        unique case (state)
            ST_PRIME: begin
                state_next = ST_RUN;
                vx_next    = '0;
                vy_next    = '0;
            end
            ST_RUN: begin
                if (vx_q == H_LAST) begin
                    vx_next = '0;
                    vy_next = (vy_q == V_LAST) ? '0 : vy_q + 11'd1;
                end else begin
                    vx_next = vx_q + 11'd1;
                end
            end
        endcase

        viden_next       = (vx_next < H_ACTIVE_W) && (vy_next < V_ACTIVE_W);
        hsync_next       = ((vx_next >= HS_START) && (vx_next < HS_END)) ? HS_POL : ~HS_POL;
        // VY only moves on the VX wrap, so VSYNC is line-aligned by construction.
        vsync_next       = ((vy_next >= VS_START) && (vy_next < VS_END)) ? VS_POL : ~VS_POL;
        line_start_next  = (vx_next == '0);
        frame_start_next = (vx_next == '0) && (vy_next == '0);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_PRIME;
        end else if (vt.en) begin
            state <= state_next;
        end
    end

    // With en low everything holds, strobes included.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vx_q          <= '0;
            vy_q          <= '0;
            viden_q       <= 1'b0;
            hsync_q       <= ~HS_POL;
            vsync_q       <= ~VS_POL;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else if (vt.en) begin
            vx_q          <= vx_next;
            vy_q          <= vy_next;
            viden_q       <= viden_next;
            hsync_q       <= hsync_next;
            vsync_q       <= vsync_next;
            line_start_q  <= line_start_next;
            frame_start_q <= frame_start_next;
        end
    end

    assign vt.VX          = vx_q;
    assign vt.VY          = vy_q;
    assign vt.VIDEN       = viden_q;
    assign vt.HSYNC       = hsync_q;
    assign vt.VSYNC       = vsync_q;
    assign vt.line_start  = line_start_q;
    assign vt.frame_start = frame_start_q;

endmodule
